// File: rtl/rom_stream_src_pkg.sv
// Shared definitions for the ROM-backed stream source.
//   state_e        : FSM state encoding (2 bits)
//   clog2_min1()   : address/counter width helper, never returns less than 1
package rom_stream_src_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2
   } state_e;

   // Width needed to count 0..value-1. A zero-width vector is not legal,
   // so depth-1 and count-1 cases still get one bit.
   function automatic int clog2_min1(input int value);
      for (int w = 1; w < 32; w++) begin
         if ((1 << w) >= value) return w;
      end
      return 32;
   endfunction

endpackage

// File: rtl/rom_stream_src_if.sv
// Stream handshake bundle between a source (master) and a sink (slave).
//   tvalid : source has a word
//   tready : sink accepts the word this cycle
//   tdata  : payload, DATA_W bits
//   tlast  : last word of a packet
interface rom_stream_src_if #(
   parameter int DATA_W = 32
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rom_stream_src_sync_rom.sv
// Synchronous-read ROM. The contents come from ROM_IMAGE, word i occupying
// bits [i*DATA_W +: DATA_W], so the image is fixed at elaboration.
//   clk   : clock
//   raddr : read address, sampled on the rising edge
//   rdata : registered word, valid one cycle after raddr
module sync_rom #(
   parameter int                      DATA_W    = 32,
   parameter int                      DEPTH     = 16,
   parameter int                      ADDR_W    = 4,
   parameter logic [DEPTH*DATA_W-1:0] ROM_IMAGE = '0
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] rom_words [DEPTH];
   logic [DATA_W-1:0] rdata_d;
   logic [DATA_W-1:0] rdata_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign rom_words[i] = ROM_IMAGE[i*DATA_W +: DATA_W];
   end

   always_comb begin
      rdata_d = '0;
      if (int'(raddr) < DEPTH) rdata_d = rom_words[raddr];
   end

   // Data path only: no reset needed, the word is ignored while tvalid=0.
   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/rom_stream_src.sv
// ROM-backed stream source. On start, streams NUM_BEATS words read from the
// ROM (address wraps at DEPTH), framing a packet every PKT_LEN beats and at
// the end of the run. Optionally loops back to word 0 without a bubble.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle pulse, honoured only when idle
//   loop_en    : restart at end of run; looked at on the final-beat transfer
//   axis       : stream master (tvalid/tready/tdata/tlast)
//   busy       : run in progress (LOAD or STREAM)
//   done       : one-cycle pulse after the final beat of a non-looping run
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start, tvalid=0
// ST_LOAD   | ROM fetching word 0, tvalid=0
// ST_STREAM | tvalid=1, advancing address/counters on each transfer
module rom_stream_src
   import rom_stream_src_pkg::*;
#(
   parameter int                      DATA_W    = 32,
   parameter int                      DEPTH     = 16,
   parameter int                      NUM_BEATS = 16,
   parameter int                      PKT_LEN   = 8,
   parameter logic [DEPTH*DATA_W-1:0] ROM_IMAGE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              loop_en,
   rom_stream_src_if.master  axis,
   output logic              busy,
   output logic              done
);

   localparam int ADDR_W = clog2_min1(DEPTH);
   localparam int BEAT_W = clog2_min1(NUM_BEATS);
   localparam int PKT_W  = clog2_min1(PKT_LEN);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_BEATS - 1);
   localparam logic [PKT_W-1:0]  PKT_LAST  = PKT_W'(PKT_LEN - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [PKT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
   logic              done_q, done_d;

   logic              streaming;
   logic              fire;
   logic              last_beat;
   logic              tlast_raw;
   logic [DATA_W-1:0] rom_rdata;

   assign streaming = (state_q == ST_STREAM);
   assign fire      = streaming & axis.tready;
   assign last_beat = (beat_cnt_q == BEAT_LAST);
   assign tlast_raw = (pkt_cnt_q == PKT_LAST) | last_beat;

   // The ROM is addressed with the next address, so the word for the
   // following beat is ready right after a transfer, and a stall simply
   // re-reads the current word, keeping tdata stable.
   sync_rom #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .ROM_IMAGE (ROM_IMAGE)
   ) u_rom (
      .clk   (clk),
      .raddr (addr_d),
      .rdata (rom_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         beat_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         beat_cnt_q <= beat_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      beat_cnt_d = beat_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (fire) begin
               if (last_beat) begin
                  // End of run: rewind everything, whether looping or not.
                  addr_d     = '0;
                  beat_cnt_d = '0;
                  pkt_cnt_d  = '0;
                  if (!loop_en) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  addr_d     = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                  pkt_cnt_d  = tlast_raw ? '0 : pkt_cnt_q + PKT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      axis.tvalid = streaming;
      axis.tdata  = rom_rdata;
      axis.tlast  = streaming & tlast_raw;
      busy        = (state_q != ST_IDLE);
      done        = done_q;
   end

endmodule

// File: tb/tb_rom_stream_src.sv
module tb_rom_stream_src;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   function automatic logic [16*32-1:0] make_image();
      logic [16*32-1:0] img;
      img = '0;
      for (int i = 0; i < 16; i++) img[i*32 +: 32] = 32'h100 + 32'(i);
      return img;
   endfunction

   localparam logic [16*32-1:0] IMG = make_image();

   logic clk;
   logic reset;
   logic start_a, start_b;
   logic loop_en_a, loop_en_b;
   logic busy_a, busy_b;
   logic done_a, done_b;

   rom_stream_src_if #(.DATA_W(32)) if_a ();
   rom_stream_src_if #(.DATA_W(32)) if_b ();

   rom_stream_src #(
      .DATA_W(32), .DEPTH(16), .NUM_BEATS(16), .PKT_LEN(8), .ROM_IMAGE(IMG)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .loop_en(loop_en_a),
      .axis(if_a), .busy(busy_a), .done(done_a)
   );

   rom_stream_src #(
      .DATA_W(32), .DEPTH(16), .NUM_BEATS(20), .PKT_LEN(6), .ROM_IMAGE(IMG)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .loop_en(loop_en_b),
      .axis(if_b), .busy(busy_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   beat_t tab_a [16];
   beat_t tab_b [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_start(input bit sel, input logic v);
      if (sel) start_b = v; else start_a = v;
   endtask

   task automatic set_ready(input bit sel, input logic v);
      if (sel) if_b.tready = v; else if_a.tready = v;
   endtask

   // One run on DUT A (sel=0) or B (sel=1). mode 0: tready held high,
   // mode 1: tready pattern 1,0,0 repeating. drop_at: beat index at which
   // loop_en_a is cleared (-1 none). start_at: beat index at which an extra
   // start pulse is issued while busy (-1 none).
   task automatic do_run(input bit sel, input int total, input int mode,
                         input int drop_at, input int start_at);
      int          k;
      int          cyc;
      int          rl;
      bit          prev_stall;
      bit          extra_sent;
      logic [31:0] pd;
      logic        pl;
      logic        tv, tr, tl, bz, dn;
      logic [31:0] td;
      beat_t       e;
      k = 0; cyc = 0; prev_stall = 0; extra_sent = 0; pd = '0; pl = 1'b0;
      rl = sel ? 20 : 16;

      @(posedge clk); #1;
      set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      @(negedge clk);
      chk("load_tvalid", sel ? if_b.tvalid : if_a.tvalid, 0);
      chk("load_busy", sel ? busy_b : busy_a, 1);

      while (k < total && cyc < 400) begin
         @(posedge clk); #1;
         if (k == drop_at) loop_en_a = 1'b0;
         if (k == start_at && !extra_sent) begin
            set_start(sel, 1'b1);
            extra_sent = 1;
         end else begin
            set_start(sel, 1'b0);
         end
         set_ready(sel, (mode == 0) ? 1'b1 : ((cyc % 3) == 0));
         @(negedge clk);
         tv = sel ? if_b.tvalid : if_a.tvalid;
         tr = sel ? if_b.tready : if_a.tready;
         td = sel ? if_b.tdata  : if_a.tdata;
         tl = sel ? if_b.tlast  : if_a.tlast;
         bz = sel ? busy_b : busy_a;
         dn = sel ? done_b : done_a;
         chk("stream_tvalid", tv, 1);
         chk("stream_busy", bz, 1);
         chk("stream_done_low", dn, 0);
         if (prev_stall) begin
            chk("stall_tdata", td, pd);
            chk("stall_tlast", tl, pl);
         end
         if (tv && tr) begin
            e = sel ? tab_b[k % rl] : tab_a[k % rl];
            chk($sformatf("beat%0d_tdata", k), td, e.data);
            chk($sformatf("beat%0d_tlast", k), tl, e.last);
            k++;
         end
         prev_stall = tv & !tr;
         pd = td;
         pl = tl;
         cyc++;
      end
      set_start(sel, 1'b0);
      if (k < total) begin
         tests++;
         fails++;
         $display("FAIL run_timeout: got %0d beats expected %0d", k, total);
      end

      @(posedge clk); #1;
      @(negedge clk);
      chk("end_tvalid", sel ? if_b.tvalid : if_a.tvalid, 0);
      chk("end_tlast", sel ? if_b.tlast : if_a.tlast, 0);
      chk("end_busy", sel ? busy_b : busy_a, 0);
      chk("end_done", sel ? done_b : done_a, 1);
      @(negedge clk);
      chk("done_pulse_1cyc", sel ? done_b : done_a, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tab_a = '{
         '{32'h100, 1'b0}, '{32'h101, 1'b0}, '{32'h102, 1'b0}, '{32'h103, 1'b0},
         '{32'h104, 1'b0}, '{32'h105, 1'b0}, '{32'h106, 1'b0}, '{32'h107, 1'b1},
         '{32'h108, 1'b0}, '{32'h109, 1'b0}, '{32'h10A, 1'b0}, '{32'h10B, 1'b0},
         '{32'h10C, 1'b0}, '{32'h10D, 1'b0}, '{32'h10E, 1'b0}, '{32'h10F, 1'b1}
      };
      tab_b = '{
         '{32'h100, 1'b0}, '{32'h101, 1'b0}, '{32'h102, 1'b0}, '{32'h103, 1'b0},
         '{32'h104, 1'b0}, '{32'h105, 1'b1}, '{32'h106, 1'b0}, '{32'h107, 1'b0},
         '{32'h108, 1'b0}, '{32'h109, 1'b0}, '{32'h10A, 1'b0}, '{32'h10B, 1'b1},
         '{32'h10C, 1'b0}, '{32'h10D, 1'b0}, '{32'h10E, 1'b0}, '{32'h10F, 1'b0},
         '{32'h100, 1'b0}, '{32'h101, 1'b1}, '{32'h102, 1'b0}, '{32'h103, 1'b1}
      };

      reset = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      loop_en_a = 1'b0; loop_en_b = 1'b0;
      if_a.tready = 1'b1; if_b.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_tvalid_a", if_a.tvalid, 0);
      chk("rst_tlast_a", if_a.tlast, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_tvalid_b", if_b.tvalid, 0);
      chk("rst_busy_b", busy_b, 0);

      // back-to-back run, then stalled run, then wrapping run on B
      do_run(0, 16, 0, -1, -1);
      do_run(0, 16, 1, -1, -1);
      do_run(1, 20, 0, -1, -1);
      do_run(1, 20, 1, -1, -1);

      // looping: 40 beats, then loop_en drops and the run ends at beat 47
      loop_en_a = 1'b1;
      do_run(0, 48, 0, 40, -1);
      loop_en_a = 1'b0;

      // reset during a stalled beat, with start asserted alongside
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      @(posedge clk); #1 if_a.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1 if_a.tready = 1'b0;
      @(negedge clk);
      chk("stall_pre_rst_tvalid", if_a.tvalid, 1);
      chk("stall_pre_rst_tdata", if_a.tdata, 32'h103);
      @(posedge clk); #1 begin reset = 1'b1; start_a = 1'b1; end
      @(posedge clk); #1 begin reset = 1'b0; start_a = 1'b0; end
      @(negedge clk);
      chk("midrun_rst_tvalid", if_a.tvalid, 0);
      chk("midrun_rst_tlast", if_a.tlast, 0);
      chk("midrun_rst_busy", busy_a, 0);
      chk("midrun_rst_done", done_a, 0);

      // start and reset together while idle: reset wins
      @(posedge clk); #1 begin reset = 1'b1; start_a = 1'b1; end
      @(posedge clk); #1 begin reset = 1'b0; start_a = 1'b0; end
      @(negedge clk);
      chk("rst_start_busy", busy_a, 0);
      @(negedge clk);
      chk("rst_start_busy_next", busy_a, 0);

      // fresh run after reset, with an ignored start pulse at beat 5
      do_run(0, 16, 0, -1, 5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_queued_run_tvalid", if_a.tvalid, 0);
         chk("no_queued_run_busy", busy_a, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
